// File: rtl/sobel_edge_if.sv
// sobel_edge_if -- pixel stream bundle between the blur stage and the edge detector.
//   i_valid       : pixel strobe into the detector
//   i_data[11:0]  : blurred pixel, low nibble is the 4-bit gray level
//   i_frame_start : one-cycle pulse marking the first pixel of a frame
//   o_valid       : edge result strobe
//   o_data[11:0]  : 12'hFFF edge / 12'h000 non-edge
//   o_edge_count  : edge pixels counted over the previous frame
// slave = detector side, master = producer/consumer side.
interface sobel_edge_if;
    logic        i_valid;
    logic [11:0] i_data;
    logic        i_frame_start;
    logic        o_valid;
    logic [11:0] o_data;
    logic [18:0] o_edge_count;

    modport slave  (input  i_valid, i_data, i_frame_start,
                    output o_valid, o_data, o_edge_count);
    modport master (output i_valid, i_data, i_frame_start,
                    input  o_valid, o_data, o_edge_count);
endinterface

// File: rtl/sobel_edge.sv
// sobel_edge -- 3x3 Sobel edge detector on a 4-bit gray pixel stream.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : sobel_edge_if.slave (pixel in, edge flag out, per-frame edge count)
// Pipeline: accept (window + line buffers) -> Gx/Gy -> |Gx|+|Gy| threshold.
// Results appear exactly 3 cycles after the accepting cycle.
module sobel_edge #(
    parameter int         IMG_WIDTH  = 640,
    parameter int         IMG_HEIGHT = 480,
    parameter logic [6:0] THRESH     = 7'd24
) (
    input  logic         clk,
    input  logic         reset,
    sobel_edge_if.slave  bus
);
    localparam int CW     = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int STAGES = 3;

    logic [3:0] gray;
    logic       accept, fs;
    logic       unused_hi;
    assign gray      = bus.i_data[3:0];
    assign accept    = bus.i_valid;
    assign fs        = bus.i_frame_start;
    assign unused_hi = ^bus.i_data[11:4];

    logic [CW-1:0] col_q, col_d, pcol;
    logic [RW-1:0] row_q, row_d, prow;
    logic [2:0][2:0][3:0] win_q, win_d;      // [row r][column k], r=2 current row, k=0 newest
    logic [STAGES:1] vld_pipe_q, vld_pipe_d;
    logic signed [7:0] gx_q, gx_d, gy_q, gy_d;
    logic        edge_q, edge_d;
    logic [18:0] cnt_q, cnt_d, ecnt_q, ecnt_d;
    logic [7:0]  ax, ay, mag;
    logic        inc;

    // Line buffers carry no reset: rows 0/1 of every frame rewrite them
    // before any window that reads them is qualified.
    logic [3:0] lb1_mem [IMG_WIDTH];
    logic [3:0] lb2_mem [IMG_WIDTH];

    // Weighted 1-2-1 column/row sum; max 60, fits easily in 8 bits.
    function automatic logic [7:0] tap3(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c);
        return {4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c};
    endfunction

    // A frame-start pixel is position (0,0) regardless of the counters.
    always_comb begin
        pcol = fs ? '0 : col_q;
        prow = fs ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pcol == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (prow == RW'(IMG_HEIGHT - 1)) ? '0 : prow + 1'b1;
            end else begin
                col_d = pcol + 1'b1;
                row_d = prow;
            end
        end else if (fs) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Window only moves on accepted pixels so gaps never inject bubbles.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = win_q[r][1];
                win_d[r][1] = win_q[r][0];
            end
            win_d[0][0] = lb2_mem[pcol];
            win_d[1][0] = lb1_mem[pcol];
            win_d[2][0] = gray;
        end
    end

    // Valid shifts every cycle; stage 1 only for fully populated windows.
    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-1:1],
                      accept && (pcol >= CW'(2)) && (prow >= RW'(2))};
    end

    always_comb begin
        gx_d = gx_q;
        gy_d = gy_q;
        if (vld_pipe_q[1]) begin
            gx_d = tap3(win_q[0][0], win_q[1][0], win_q[2][0])
                 - tap3(win_q[0][2], win_q[1][2], win_q[2][2]);
            gy_d = tap3(win_q[2][0], win_q[2][1], win_q[2][2])
                 - tap3(win_q[0][0], win_q[0][1], win_q[0][2]);
        end
    end

    always_comb begin
        ax     = gx_q[7] ? 8'(-gx_q) : gx_q;
        ay     = gy_q[7] ? 8'(-gy_q) : gy_q;
        mag    = ax + ay;
        edge_d = edge_q;
        if (vld_pipe_q[2]) edge_d = (mag >= {1'b0, THRESH});
    end

    // The count of the closing frame includes an edge output in the same cycle.
    always_comb begin
        inc    = vld_pipe_q[STAGES] & edge_q;
        cnt_d  = fs ? '0 : cnt_q + 19'(inc);
        ecnt_d = fs ? cnt_q + 19'(inc) : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            lb2_mem[pcol] <= lb1_mem[pcol];
            lb1_mem[pcol] <= gray;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            vld_pipe_q <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            edge_q     <= 1'b0;
            cnt_q      <= '0;
            ecnt_q     <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            vld_pipe_q <= vld_pipe_d;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign bus.o_valid      = vld_pipe_q[STAGES];
    assign bus.o_data       = {12{edge_q}};
    assign bus.o_edge_count = ecnt_q;
endmodule
